// File: rtl/m_vmem_ctrl.sv
// m_vmem_ctrl: 256x256 RGB565 frame buffer with a pixel/rectangle fill engine.
// Define VMEM_CLEAR_EN to sweep CLEAR_COLOR over vmem after every reset.
module m_vmem_ctrl #(
  parameter logic [15:0] CLEAR_COLOR = 16'h0000,
  parameter int          DEPTH_LOG2  = 16
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_op,
  input  logic [7:0]            i_x0,
  input  logic [7:0]            i_y0,
  input  logic [7:0]            i_x1,
  input  logic [7:0]            i_y1,
  input  logic [15:0]           i_color,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic [DEPTH_LOG2-1:0] w_raddr,
  output logic [15:0]           w_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE,
    S_CLEAR
  } state_t;

`ifdef VMEM_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
`else
  localparam state_t RST_STATE = S_IDLE;
`endif

  logic [15:0] vmem [DEPTH];

  state_t      state, state_nxt;
  logic [7:0]  x0, x0_nxt;
  logic [7:0]  x1, x1_nxt;
  logic [7:0]  y1, y1_nxt;
  logic [15:0] color, color_nxt;
  logic [7:0]  cx, cx_nxt;
  logic [7:0]  cy, cy_nxt;

  logic [7:0]  cmd_x1;
  logic [7:0]  cmd_y1;
  logic        we;
  logic [15:0] wdata;

  // A pixel write is a 1x1 rectangle.
  assign cmd_x1 = i_cmd_op ? i_x1 : i_x0;
  assign cmd_y1 = i_cmd_op ? i_y1 : i_y0;

  assign o_cmd_ready = (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state <= RST_STATE;
      x0    <= '0;
      x1    <= '0;
      y1    <= '0;
      color <= '0;
      cx    <= '0;
      cy    <= '0;
    end else begin
      state <= state_nxt;
      x0    <= x0_nxt;
      x1    <= x1_nxt;
      y1    <= y1_nxt;
      color <= color_nxt;
      cx    <= cx_nxt;
      cy    <= cy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x0_nxt    = x0;
    x1_nxt    = x1;
    y1_nxt    = y1;
    color_nxt = color;
    cx_nxt    = cx;
    cy_nxt    = cy;
    unique case (state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          x0_nxt    = i_x0;
          x1_nxt    = cmd_x1;
          y1_nxt    = cmd_y1;
          color_nxt = i_color;
          cx_nxt    = i_x0;
          cy_nxt    = i_y0;
          if (cmd_x1 >= i_x0 && cmd_y1 >= i_y0)
            state_nxt = S_FILL;
          else
            state_nxt = S_DONE;
        end
      end
      S_FILL: begin
        if (cx == x1) begin
          cx_nxt = x0;
          // Hold cy on the last row so the cursor never wraps.
          if (cy == y1)
            state_nxt = S_DONE;
          else
            cy_nxt = cy + 8'd1;
        end else begin
          cx_nxt = cx + 8'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
`ifdef VMEM_CLEAR_EN
      S_CLEAR: begin
        {cy_nxt, cx_nxt} = {cy, cx} + 16'd1;
        if ({cy, cx} == 16'hFFFF)
          state_nxt = S_DONE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Gate with reset so an aborted fill stops on the reset edge itself.
  assign we    = w_rst_n && (state == S_FILL || state == S_CLEAR);
  assign wdata = (state == S_CLEAR) ? CLEAR_COLOR : color;

  always_ff @(posedge w_clk) begin
    if (we)
      vmem[{cy, cx}] <= wdata;
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n)
      w_rdata <= '0;
    else
      w_rdata <= vmem[w_raddr];
  end

endmodule

// File: tb/tb_m_vmem_ctrl.sv
// tb_m_vmem_ctrl: directed bench for the video-memory fill engine.
// Default build (VMEM_CLEAR_EN undefined).
module tb_m_vmem_ctrl;

  localparam int LIM = 70000;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_op;
  logic [7:0]  i_x0, i_y0, i_x1, i_y1;
  logic [15:0] i_color;
  logic        o_busy;
  logic        o_done;
  logic [15:0] w_raddr;
  logic [15:0] w_rdata;

  int n_run = 0;
  int n_fail = 0;
  logic [15:0] hist [8];

  m_vmem_ctrl dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_x0        (i_x0),
    .i_y0        (i_y0),
    .i_x1        (i_x1),
    .i_y1        (i_y1),
    .i_color     (i_color),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .w_raddr     (w_raddr),
    .w_rdata     (w_rdata)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic drive(input logic op, input logic [7:0] x0,
                       input logic [7:0] y0, input logic [7:0] x1,
                       input logic [7:0] y1, input logic [15:0] c);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_x0        = x0;
    i_y0        = y0;
    i_x1        = x1;
    i_y1        = y1;
    i_color     = c;
  endtask

  // Accept at edge T; k = edges after T until o_done is seen.
  task automatic run_cmd(input string tag, input logic op,
                         input logic [7:0] x0, input logic [7:0] y0,
                         input logic [7:0] x1, input logic [7:0] y1,
                         input logic [15:0] c, output int k);
    chk({tag, "_ready"}, o_cmd_ready, 1);
    drive(op, x0, y0, x1, y1, c);
    step();
    i_cmd_valid = 1'b0;
    hist[0] = w_rdata;
    k = 0;
    while (!o_done && k < LIM) begin
      step();
      k++;
      if (k < 8) hist[k] = w_rdata;
    end
    if (k >= LIM) chk({tag, "_timeout"}, k, 0);
  endtask

  // One cycle after done: pulse gone, ready back.
  task automatic post_done(input string tag);
    step();
    chk({tag, "_done_low"}, o_done, 0);
    chk({tag, "_ready_back"}, o_cmd_ready, 1);
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    w_raddr = a;
    step();
    d = w_rdata;
  endtask

  task automatic pix(input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] c);
    int k;
    run_cmd("pre", 1'b0, x, y, 8'd0, 8'd0, c, k);
    chk("pre_cycles", k, 1);
    step();
  endtask

  initial begin
    int k;
    logic [15:0] d;
    logic bad;
    w_rst_n     = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_op    = 1'b0;
    i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0;
    i_color     = '0;
    w_raddr     = '0;
    step();
    step();
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rdata", w_rdata, 0);
    w_rst_n = 1'b1;
    step();

    // Pixel write with junk in x1/y1 that op=0 must ignore.
    run_cmd("pix", 1'b0, 8'd10, 8'd20, 8'd200, 8'd200, 16'hF800, k);
    chk("pix_cycles", k, 1);
    post_done("pix");
    rd(16'h140A, d);
    chk("pix_rd", d, 16'hF800);
    rd(16'h140B, d);
    chk("pix_nb", d, 16'h0000);

    // Rectangle, with marked neighbours; watch 0507 during the fill.
    pix(8'd4, 8'd5, 16'h1111);
    pix(8'd8, 8'd5, 16'h2222);
    pix(8'd7, 8'd5, 16'h3333);
    w_raddr = 16'h0507;
    run_cmd("rect", 1'b1, 8'd5, 8'd5, 8'd7, 8'd6, 16'h07E0, k);
    chk("rect_cycles", k, 6);
    chk("rect_busy", o_busy, 1);
    chk("rect_coll", hist[3], 16'h3333);
    chk("rect_order", hist[4], 16'h07E0);
    post_done("rect");
    rd(16'h0505, d); chk("rect_0505", d, 16'h07E0);
    rd(16'h0506, d); chk("rect_0506", d, 16'h07E0);
    rd(16'h0605, d); chk("rect_0605", d, 16'h07E0);
    rd(16'h0607, d); chk("rect_0607", d, 16'h07E0);
    rd(16'h0504, d); chk("rect_0504", d, 16'h1111);
    rd(16'h0508, d); chk("rect_0508", d, 16'h2222);

    // Degenerate rectangle x1 < x0.
    pix(8'd9, 8'd3, 16'h4444);
    run_cmd("degen", 1'b1, 8'd9, 8'd3, 8'd8, 8'd3, 16'h5555, k);
    chk("degen_cycles", k, 0);
    post_done("degen");
    rd(16'h0309, d); chk("degen_nowr", d, 16'h4444);

    // Backpressure: valid held high with a new command during a fill.
    pix(8'd50, 8'd50, 16'h7777);
    drive(1'b1, 8'd0, 8'd40, 8'd3, 8'd40, 16'h4040);
    step();
    drive(1'b0, 8'd50, 8'd50, 8'd0, 8'd0, 16'h6666);
    bad = 1'b0;
    k = 0;
    while (!o_done && k < LIM) begin
      if (o_cmd_ready) bad = 1'b1;
      step();
      k++;
    end
    chk("bp_cycles", k, 4);
    chk("bp_no_accept", bad, 0);
    i_cmd_valid = 1'b0;
    post_done("bp");
    rd(16'h3232, d); chk("bp_b_ignored", d, 16'h7777);
    rd(16'h2803, d); chk("bp_a_last", d, 16'h4040);

    // Bottom-right corner.
    run_cmd("corner", 1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 16'hABCD, k);
    chk("corner_cycles", k, 1);
    post_done("corner");
    rd(16'hFFFF, d); chk("corner_rd", d, 16'hABCD);

    // Full-screen fill aborted by reset after 100 writes.
    pix(8'd99, 8'd0, 16'h1234);
    pix(8'd100, 8'd0, 16'h8888);
    chk("abort_ready", o_cmd_ready, 1);
    drive(1'b1, 8'd0, 8'd0, 8'd255, 8'd255, 16'h0F0F);
    step();
    i_cmd_valid = 1'b0;
    bad = 1'b0;
    repeat (100) begin
      step();
      if (o_done) bad = 1'b1;
    end
    w_rst_n = 1'b0;
    step();
    chk("abort_ready_rst", o_cmd_ready, 1);
    chk("abort_busy_rst", o_busy, 0);
    chk("abort_done_rst", o_done, 0);
    chk("abort_rdata_rst", w_rdata, 0);
    w_rst_n = 1'b1;
    repeat (3) begin
      step();
      if (o_done) bad = 1'b1;
    end
    chk("abort_no_done", bad, 0);
    rd(16'h0000, d); chk("abort_first", d, 16'h0F0F);
    rd(16'h0063, d); chk("abort_100th", d, 16'h0F0F);
    rd(16'h0064, d); chk("abort_101st", d, 16'h8888);
    run_cmd("after", 1'b0, 8'd1, 8'd2, 8'd0, 8'd0, 16'hBEEF, k);
    chk("after_cycles", k, 1);
    post_done("after");
    rd(16'h0201, d); chk("after_rd", d, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/m_vmem_ctrl.md
Name: m_vmem_ctrl

Overview:
- Video-memory controller that sits directly upstream of the ST7789 display driver.
- Owns the 256x256 x 16-bit RGB565 frame buffer (vmem, 65,536 words). Serves the driver's read port (w_raddr/w_rdata).
- Writes pixels into vmem from a CPU/MMIO command port.
- A hardware fill engine executes single-pixel writes and inclusive rectangle fills, one pixel per clock.

Parameters:
- CLEAR_COLOR, 16'h0000, RGB565 value written by the power-up clear sweep (VMEM_CLEAR_EN only).
- DEPTH_LOG2, 16, vmem address width; fixed at 16 ({y[7:0], x[7:0]}); any other value is illegal.

Ports:
- w_clk  input  1  main clock (100 MHz)
- w_rst_n  input  1  reset, synchronous, active-low
- i_cmd_valid  input  1  command request
- o_cmd_ready  output  1  high only in IDLE; command accepted on valid&&ready
- i_cmd_op  input  1  0 = pixel write at (x0,y0); 1 = rectangle fill
- i_x0  input  8  start column
- i_y0  input  8  start row
- i_x1  input  8  end column, inclusive (op=1 only)
- i_y1  input  8  end row, inclusive (op=1 only)
- i_color  input  16  RGB565 pixel value
- o_busy  output  1  high while the engine is not in IDLE
- o_done  output  1  one-cycle pulse when a command finishes
- w_raddr  input  16  display read address {y,x}
- w_rdata  output  16  registered read data

Behaviour:
- Reset (w_rst_n low at a w_clk edge):
  - State goes to IDLE (CLEAR with macro).
  - o_cmd_ready=1 (0 with macro), o_busy=0 (1 with macro), o_done=0, w_rdata=0.
  - vmem contents are not modified by reset itself.
  - Reset mid-fill aborts the fill: no further writes and no o_done.
- Read port:
  - w_rdata <= vmem[w_raddr] every cycle; latency 1; independent of engine state.
  - Read and write to the same address in the same cycle returns the old data.
- Command capture:
  - On valid&&ready, register op, coordinates and color.
  - op=0 forces x1=x0, y1=y0. Inputs are ignored while ready=0.
- States:
  - IDLE:
    - ready=1.
    - On accept, go to FILL if x1>=x0 and y1>=y0. Cursor is set to (x0,y0).
    - Otherwise go to DONE with no writes (degenerate rectangle).
  - FILL:
    - Each cycle writes vmem[{cy,cx}]=color.
    - If cx==x1: cx<=x0, cy<=cy+1; otherwise cx<=cx+1.
    - After writing (x1,y1), go to DONE.
    - Order is row-major, left to right.
  - DONE:
    - o_done=1 for exactly one cycle, then go to IDLE.
  - CLEAR (macro only): described under Optional Feature.
- Cursor arithmetic is 8-bit. Because x1/y1 are 8-bit inclusive bounds, the cursor never wraps past 255.
- Timing for a command accepted at edge T, with N=(x1-x0+1)*(y1-y0+1) pixels:
  - Writes occur on edges T+1..T+N.
  - o_done is high during the cycle after edge T+N.
  - ready returns after edge T+N+1.
  - Pixel command (N=1): write at T+1, done high after T+1, next accept possible at T+3.
- Full screen 240x240 takes 57,600 cycles; 256x256 takes 65,536 cycles.
- o_busy = (state != IDLE).

Optional Feature:
- Macro: VMEM_CLEAR_EN.
- Defined:
  - After every reset the engine enters CLEAR.
  - It writes CLEAR_COLOR to addresses 0..65535, one per cycle.
  - It then pulses o_done once and enters IDLE.
  - ready=0 and busy=1 throughout CLEAR.
  - A reset during CLEAR restarts the sweep at address 0.
- Undefined:
  - No CLEAR state; reset goes directly to IDLE.
  - vmem power-up contents are the FPGA initial value (zero).

Test Plan:
- Pixel write: op=0, (10,20), color 16'hF800, accepted at T -> vmem[16'h140A]=F800 at T+1; o_done high one cycle after T+1; reading 16'h140A returns F800 one cycle after the address is presented.
- Rectangle fill: op=1, (5,5)-(7,6), color 16'h07E0 -> exactly 6 writes, row-major: 0505, 0506, 0507, 0605, 0606, 0607; neighbours 0504 and 0508 unchanged; o_done one cycle after the 6th write.
- Degenerate rectangle: x0=9, x1=8 -> zero writes; o_done at T+1; ready back at T+2.
- Backpressure and corner: valid held during a fill -> no second accept until IDLE. Fill (255,255)-(255,255) writes only 16'hFFFF, with no cursor wrap.
- Reset mid-fill: full-screen fill aborted at write 100 -> exactly 100 pixels written; outputs at reset values; no o_done; next command accepted normally.
- Macro build with VMEM_CLEAR_EN and CLEAR_COLOR=16'h001F: after reset, busy for 65,536 cycles; single o_done; vmem[0] and vmem[FFFF] both equal 001F; read/write collision returns old data.
